// File: rtl/lifo_stack_pkg.sv
// Shared types and sizing helpers for the parametrised LIFO stack.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module lifo_stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     top_addr_i,
  output logic [DATA_W-1:0] top_data_o,
  input  logic [AW-1:0]     pop_addr_i,
  output logic [DATA_W-1:0] pop_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign top_data_o = mem_q[top_addr_i];
  assign pop_data_o = mem_q[pop_addr_i];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with registered pop path, top peek, replace-top,
// occupancy/almost-full flags and sticky overflow/underflow errors.
module lifo_stack_param
  import lifo_stack_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  DEPTH     = 16,
  parameter int  AF_THRESH = DEPTH - 2,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic [DATA_W-1:0] top_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int AW = addr_w(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  op_e               op;
  logic              empty, full;
  logic [CNT_W:0]    cnt_ext, top_ext;
  logic [AW-1:0]     top_addr, cnt_addr, waddr;
  logic              we;
  logic [DATA_W-1:0] rd_top, rd_pop;
  logic              unused_hi;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    case ({push_i, pop_i})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NONE;
    endcase
  end

  // Extended by one bit so count-1 at empty stays well defined; only low bits address storage.
  assign cnt_ext   = {1'b0, count_q};
  assign top_ext   = cnt_ext - 1'b1;
  assign top_addr  = top_ext[AW-1:0];
  assign cnt_addr  = cnt_ext[AW-1:0];
  assign unused_hi = ^{top_ext[CNT_W:AW], cnt_ext[CNT_W:AW]};

  // Replace overwrites the top; push (including push+pop on empty) writes at count.
  assign waddr = (op == OP_REPLACE && !empty) ? top_addr : cnt_addr;
  assign we    = !rst && !flush_i &&
                 ((op == OP_PUSH && !full) || op == OP_REPLACE);

  lifo_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk        (clk),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (push_data_i),
    .top_addr_i (top_addr),
    .top_data_o (rd_top),
    .pop_addr_i (top_addr),
    .pop_data_o (rd_pop)
  );

  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = clr_err_i ? 1'b0 : ovf_q;
    unf_d       = clr_err_i ? 1'b0 : unf_q;
    if (flush_i) begin
      count_d = '0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) ovf_d = 1'b1;
          else      count_d = count_q + 1'b1;
        end
        OP_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pop_data_d  = rd_pop;
            pop_valid_d = 1'b1;
            count_d     = count_q - 1'b1;
          end
        end
        OP_REPLACE: begin
          if (empty) begin
            count_d = CNT_W'(1);
            unf_d   = 1'b1;
          end else begin
            pop_data_d  = rd_pop;
            pop_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign pop_data_o    = pop_data_q;
  assign pop_valid_o   = pop_valid_q;
  assign top_data_o    = empty ? '0 : rd_top;
  assign count_o       = count_q;
  assign empty_o       = empty;
  assign full_o        = full;
  assign almost_full_o = (count_q >= CNT_W'(AF_THRESH));
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench: directed vector table, then random traffic vs a queue model.
module tb_lifo_stack_param;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AF = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0, pop = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] pop_data, top_data;
  logic          pop_valid, empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lifo_stack_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_data_i   (din),
    .pop_i         (pop),
    .flush_i       (flush),
    .clr_err_i     (clr),
    .pop_data_o    (pop_data),
    .pop_valid_o   (pop_valid),
    .top_data_o    (top_data),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  typedef struct {
    logic       rst, push, pop, flush, clr;
    logic [7:0] data;
    int         cnt;
    logic [7:0] top;
    logic       pv;
    logic [7:0] pd;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_pd;
  logic       m_pv, m_ovf, m_unf;

  function automatic vec_t mk(logic r, logic pu, logic po, logic fl, logic cl,
                              logic [7:0] d, int c, logic [7:0] t, logic v,
                              logic [7:0] p, logic o, logic u);
    vec_t x;
    x.rst = r; x.push = pu; x.pop = po; x.flush = fl; x.clr = cl; x.data = d;
    x.cnt = c; x.top = t; x.pv = v; x.pd = p; x.ovf = o; x.unf = u;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic pu, input logic po, input logic fl,
                       input logic cl, input logic [7:0] d);
    rst = r; push = pu; pop = po; flush = fl; clr = cl; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input logic [7:0] t,
                           input logic v, input logic [7:0] p, input logic o, input logic u);
    chk({tag, ".count"},       32'(count),       32'(c));
    chk({tag, ".top_data"},    32'(top_data),    32'(t));
    chk({tag, ".pop_valid"},   32'(pop_valid),   32'(v));
    chk({tag, ".pop_data"},    32'(pop_data),    32'(p));
    chk({tag, ".overflow"},    32'(overflow),    32'(o));
    chk({tag, ".underflow"},   32'(underflow),   32'(u));
    chk({tag, ".empty"},       32'(empty),       32'(c == 0));
    chk({tag, ".full"},        32'(full),        32'(c == DP));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(c >= AF));
  endtask

  task automatic model_step(input logic r, input logic pu, input logic po, input logic fl,
                            input logic cl, input logic [7:0] d);
    if (r) begin
      mq.delete(); m_pd = '0; m_pv = 0; m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      mq.delete(); m_pv = 0;
    end else begin
      m_pv = 0;
      if (cl) begin m_ovf = 0; m_unf = 0; end
      if (pu && po) begin
        if (mq.size() > 0) begin
          m_pd = mq[$]; m_pv = 1; mq[mq.size()-1] = d;
        end else begin
          mq.push_back(d); m_unf = 1;
        end
      end else if (pu) begin
        if (mq.size() == DP) m_ovf = 1;
        else mq.push_back(d);
      end else if (po) begin
        if (mq.size() == 0) m_unf = 1;
        else begin m_pd = mq.pop_back(); m_pv = 1; end
      end
    end
  endtask

  initial begin
    //           rst pu po fl cl data   cnt top   pv pd     ovf unf
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h99, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h99, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h11, 1, 8'h11, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h22, 2, 8'h22, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h33, 3, 8'h33, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h44, 4, 8'h44, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h55, 4, 8'h44, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 3, 8'h33, 1, 8'h44, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 2, 8'h22, 1, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 8'h11, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h11, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'hA1, 1, 8'hA1, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'hA2, 2, 8'hA2, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hB0, 2, 8'hB0, 1, 8'hA2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'hC3, 3, 8'hC3, 0, 8'hA2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'hC4, 4, 8'hC4, 0, 8'hA2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hD0, 4, 8'hD0, 1, 8'hC4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h77, 4, 8'hD0, 0, 8'hC4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'hEE, 0, 8'h00, 0, 8'hC4, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h5A, 1, 8'h5A, 0, 8'hC4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 8'h5A, 0, 8'hC4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h5A, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h01, 1, 8'h01, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h02, 2, 8'h02, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h03, 3, 8'h03, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h09, 0, 8'h00, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h10, 1, 8'h10, 0, 8'h5A, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h20, 0, 8'h00, 0, 8'h00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top, vecs[i].pv,
                vecs[i].pd, vecs[i].ovf, vecs[i].unf);
    end

    // Pop pulse must drop on the cycle after a pop with no new request.
    cycle(0, 1, 0, 0, 0, 8'h3C);
    cycle(0, 0, 1, 0, 0, 8'h00);
    chk("pulse.hi", 32'(pop_valid), 32'd1);
    cycle(0, 0, 0, 0, 0, 8'h00);
    chk("pulse.lo", 32'(pop_valid), 32'd0);
    chk("pulse.hold", 32'(pop_data), 32'h3C);

    // Random traffic against the queue model.
    cycle(1, 0, 0, 0, 0, 8'h00);
    model_step(1, 0, 0, 0, 0, 8'h00);
    for (int n = 0; n < 800; n++) begin
      logic r, pu, po, fl, cl;
      logic [7:0] d;
      r  = ($urandom_range(0, 99) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 31) == 0);
      cl = ($urandom_range(0, 9) == 0);
      d  = 8'($urandom);
      cycle(r, pu, po, fl, cl, d);
      model_step(r, pu, po, fl, cl, d);
      check_all($sformatf("rnd%0d", n), mq.size(),
                (mq.size() > 0) ? mq[$] : 8'h00, m_pv, m_pd, m_ovf, m_unf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
- Parametrised LIFO stack, the successor to the fixed 4-bit/16-entry stack used for call/return and data stacking in the controller datapath.
- Adds configurable width and depth, a registered pop path with a valid pulse, and a zero-latency top-of-stack peek.
- Adds legal simultaneous push+pop (replace top), occupancy count, almost-full flag, sticky overflow/underflow errors and synchronous flush.
- Sits between the stack data mux and the sequencer, which consumes pop_data/pop_valid.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2, any integer, not restricted to a power of two).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  push request.
- push_data  in  DATA_W  word to push.
- pop  in  1  pop request.
- flush  in  1  synchronous empty-the-stack request.
- clr_err  in  1  clears sticky error flags.
- pop_data  out  DATA_W  registered popped word.
- pop_valid  out  1  one-cycle pulse: pop_data updated this cycle.
- top_data  out  DATA_W  current top entry, combinational peek.
- count  out  CNT_W=$clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count>=AF_THRESH.
- overflow  out  1  sticky, a push was rejected.
- underflow  out  1  sticky, a pop was rejected.

Behaviour:
- Reset:
  - Registered outputs after rst: count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Derived outputs follow: empty=1, full=0, almost_full=0 (0 since AF_THRESH>=1), top_data=0.
  - Storage array is not reset.
  - rst overrides all other inputs, including mid-operation.
- Storage: mem[0..DEPTH-1]; the top entry is mem[count-1].
- top_data = mem[count-1] when !empty, otherwise 0. It is purely combinational and reflects the state after the last clock edge.
- flush (after rst in priority): count<=0 and pop_valid<=0. push/pop in the same cycle are ignored and flag no errors. pop_data and the error flags are unchanged.
- Per-cycle cases, evaluated when neither rst nor flush is asserted:
  - push only, !full: mem[count]<=push_data, count<=count+1.
  - push only, full: rejected, overflow<=1, no state change.
  - pop only, !empty: pop_data<=mem[count-1], pop_valid<=1, count<=count-1.
  - pop only, empty: rejected, underflow<=1, pop_valid<=0.
  - push+pop, !empty (including full): replace top. pop_data<=old mem[count-1], pop_valid<=1, mem[count-1]<=push_data, count unchanged, no error.
  - push+pop, empty: push accepted (mem[0]<=push_data, count<=1), pop rejected, underflow<=1, pop_valid<=0.
  - neither: pop_valid<=0.
- Pop latency: one cycle. pop_data appears on the edge that completes the pop; pop_data holds its value between pops.
- Error flags:
  - Sticky until rst or clr_err.
  - If clr_err coincides with a new error event in the same cycle, the set wins.
- Counter and pointer arithmetic is in CNT_W bits with no wrap-around; the rejection rules above guarantee count stays in 0..DEPTH.
- Indexing uses count directly, so any DEPTH value works with no pointer wrap.

Decomposition:
- Package lifo_stack_pkg:
  - function clog2-based CNT_W helper.
  - typedef enum of the operation codes {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}, used for decode and coverage.
- Sub-module lifo_stack_mem (DATA_W, DEPTH):
  - one synchronous write port (we, waddr, wdata);
  - two asynchronous read ports (top read at count-1, pop read).
  - The top read and pop read may share the same address.
- Top level lifo_stack_param holds the op decode, count register, flags and pop_data register.

Test Plan:
- All tests use DATA_W=8, DEPTH=4, AF_THRESH=3.
- Reset: hold rst 2 cycles with push=1 -> count=0, empty=1, pop_valid=0, overflow=0, top_data=0.
- Fill and overflow:
  - push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full=1 at count=3, full=1 at 4, top_data=0x44.
  - 5th push 0x55 -> overflow=1, count=4, top_data=0x44.
- Drain and underflow:
  - 4 pops -> pop_data 0x44,0x33,0x22,0x11, each with a one-cycle pop_valid pulse; empty=1.
  - 5th pop -> underflow=1, pop_valid=0.
- Replace top:
  - push 0xA1,0xA2, then push+pop with 0xB0 -> pop_data=0xA2, pop_valid=1, count=2, top_data=0xB0.
  - Repeat while full -> no overflow.
- Push+pop on empty with 0x5A -> count=1, top_data=0x5A, underflow=1, pop_valid=0.
- Flush and clear:
  - count=3, then flush with push=1 -> count=0, no overflow, pop_data unchanged.
  - clr_err -> overflow=0, underflow=0.
  - clr_err together with a pop on empty -> underflow stays 1.
